scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 117 +++++++++++
 tb/tb_scan_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// scan_sequencer: serial scan-chain transaction sequencer (SELECT, SHIFT NBITS bits, LATCH).
// Ports:
//   clk          - sole clock, rising edge
//   reset        - asynchronous active-low reset
//   start        - request a transaction (sampled only in IDLE)
//   abort        - synchronous cancel of the current transaction
//   addr         - design select, captured at start, sent on tdi during SELECT
//   wr_data      - NBITS data shifted out MSB first, captured at start
//   tdo          - serial data returned from the scan chain
//   tck/tms/tdi  - scan clock, mode select and serial data out
//   rd_data      - bits captured from tdo, updated only on completion
//   busy         - transaction in progress
//   done         - one-cycle completion pulse
module scan_sequencer #(
    parameter int CLK_DIV = 2,
    parameter int NBITS   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             addr,
    input  logic [NBITS-1:0] wr_data,
    input  logic             tdo,
    output logic             tck,
    output logic             tms,
    output logic             tdi,
    output logic [NBITS-1:0] rd_data,
    output logic             busy,
    output logic             done
);
    localparam int BW = NBITS > 1 ? $clog2(NBITS) : 1;
    typedef enum logic [2:0] {IDLE, SELECT, SHIFT, LATCH, DONE} state_t;
    state_t           state_q;
    logic [7:0]       hcnt_q;
    logic [BW-1:0]    bcnt_q;
    logic [NBITS-1:0] tx_q;
    logic [NBITS-1:0] rx_q;
    logic             half_end;
    logic             last_bit;
    assign half_end = hcnt_q == 8'(CLK_DIV - 1);
    assign last_bit = bcnt_q == BW'(NBITS - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            tck     <= 1'b0;
            tms     <= 1'b0;
            tdi     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_data <= '0;
        end else if (abort && state_q != IDLE) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            tck     <= 1'b0;
            tms     <= 1'b0;
            tdi     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: if (start && !abort) begin
                    state_q <= SELECT;
                    tx_q    <= wr_data;
                    hcnt_q  <= '0;
                    bcnt_q  <= '0;
                    tck     <= 1'b0;
                    tms     <= 1'b1;
                    tdi     <= addr;
                    busy    <= 1'b1;
                end
                DONE: state_q <= IDLE;
                default: begin
                    // In LATCH a non-zero bit counter marks the trailing tck-low cycle after the last pulse.
                    if (state_q == LATCH && bcnt_q != '0) begin
                        state_q <= DONE;
                        bcnt_q  <= '0;
                        tms     <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rd_data <= rx_q;
                    end else if (!half_end) begin
                        hcnt_q <= hcnt_q + 8'd1;
                    end else if (!tck) begin
                        hcnt_q <= '0;
                        tck    <= 1'b1;
                        if (state_q == SHIFT) rx_q <= NBITS'({rx_q, tdo});
                    end else begin
                        // End of a pulse: the next low phase starts here, so tdi changes only now.
                        hcnt_q <= '0;
                        tck    <= 1'b0;
                        if (state_q == LATCH) begin
                            bcnt_q <= BW'(1);
                        end else if (state_q == SELECT || !last_bit) begin
                            state_q <= SHIFT;
                            tms     <= 1'b0;
                            tdi     <= tx_q[NBITS-1];
                            tx_q    <= tx_q << 1;
                            if (state_q == SHIFT) bcnt_q <= bcnt_q + BW'(1);
                        end else begin
                            state_q <= LATCH;
                            tms     <= 1'b1;
                            tdi     <= 1'b0;
                            bcnt_q  <= '0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: scoreboard bench for scan_sequencer (CLK_DIV=2 main DUT, CLK_DIV=1 timing DUT).
module tb_scan_sequencer;
    logic       clk = 1'b0, reset = 1'b0, start = 1'b0, start2 = 1'b0, abort = 1'b0, addr = 1'b0, tdo = 1'b0;
    logic [7:0] wr_data = '0, rd_data, rd2;
    logic       tck, tms, tdi, busy, done, tck2, tms2, tdi2, busy2, done2;
    int         cyc = 0, checks = 0, errors = 0;
    typedef struct {int acc; int dcyc; logic a; logic [7:0] rd; logic [9:0] tdi_seq;} exp_t;
    exp_t       q[$];
    int         free_edge = 0, m_acc = -100, rise_cnt = 0;
    logic [7:0] cur_tdo = '0, nxt_tdo = '0, last_rd = '0;
    logic [9:0] obs_tdi = '0, obs_tms = '0;
    logic       prev_tck = 1'b0;

    scan_sequencer #(.CLK_DIV(2), .NBITS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .addr(addr), .wr_data(wr_data), .tdo(tdo),
        .tck(tck), .tms(tms), .tdi(tdi), .rd_data(rd_data), .busy(busy), .done(done));
    scan_sequencer #(.CLK_DIV(1), .NBITS(8)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(1'b0), .addr(addr), .wr_data(wr_data), .tdo(1'b0),
        .tck(tck2), .tms(tms2), .tdi(tdi2), .rd_data(rd2), .busy(busy2), .done(done2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %0h exp %0h", n, cyc, got, exp);
        end
    endtask

    // Reference model: decides acceptance of the upcoming edge from the transaction rules, then advances one cycle.
    task automatic tick();
        exp_t x;
        int   e;
        e = cyc + 1;
        if (abort) begin
            if (e <= m_acc + 41) begin
                q.delete();
                m_acc = -100;
                free_edge = e + 1;
            end
        end else if (start && e >= free_edge) begin
            x.acc = e; x.dcyc = e + 41; x.a = addr; x.rd = nxt_tdo; x.tdi_seq = {addr, wr_data, 1'b0};
            q.push_back(x);
            m_acc = e;
            free_edge = e + 43;
            cur_tdo = nxt_tdo;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        free_edge = 0;
        m_acc = -100;
        last_rd = '0;
    endtask

    // Monitor: records each tck rise, drives tdo for the scan chain, and pops the scoreboard on completion.
    always @(negedge clk) begin
        if (q.size() > 0 && cyc == q[0].acc) begin
            chk("busy_after_start", busy, 1);
            chk("select_tms", tms, 1);
            chk("select_tdi", tdi, q[0].a);
        end
        if (busy && tck && !prev_tck) begin
            obs_tdi = {obs_tdi[8:0], tdi};
            obs_tms = {obs_tms[8:0], tms};
            rise_cnt++;
        end
        if (q.size() > 0 && cyc == q[0].dcyc) begin
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
            chk("rd_data", rd_data, q[0].rd);
            chk("tck_rises", rise_cnt, 10);
            chk("tdi_seq", obs_tdi, q[0].tdi_seq);
            chk("tms_seq", obs_tms, 10'b1000000001);
            last_rd = q[0].rd;
            q.pop_front();
        end else begin
            chk("no_done", done, 0);
        end
        if (!busy) begin
            rise_cnt = 0;
            obs_tdi = '0;
            obs_tms = '0;
        end
        tdo = (rise_cnt >= 1 && rise_cnt <= 8) ? cur_tdo[8-rise_cnt] : 1'b0;
        prev_tck = tck;
    end

    initial begin
        int a, lat, rises, tog;
        logic p;
        repeat (3) @(negedge clk);
        chk("rst_tck", tck, 0); chk("rst_tms", tms, 0); chk("rst_tdi", tdi, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_rd", rd_data, 0);
        #1 reset = 1'b1;
        tick();
        // Directed write/read: addr=1, 0xA5 out, tdo 0,0,1,1,1,1,0,0 -> 0x3C.
        addr = 1'b1; wr_data = 8'hA5; nxt_tdo = 8'h3C; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (45) tick();
        // Start pulse mid-transaction ignored; start held through DONE accepted the cycle after done.
        a = cyc + 1;
        addr = 1'b0; wr_data = 8'h5A; nxt_tdo = 8'hC3; start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < a + 9) tick();
        start = 1'b1; wr_data = 8'hFF;
        tick();
        start = 1'b0;
        while (cyc < a + 38) tick();
        addr = 1'b1; wr_data = 8'h81; nxt_tdo = 8'h7E; start = 1'b1;
        while (cyc < a + 45) tick();
        chk("held_start_accepted", m_acc, a + 43);
        start = 1'b0;
        repeat (45) tick();
        // Abort during SHIFT bit 4.
        addr = 1'b1; wr_data = 8'h96; nxt_tdo = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && rise_cnt < 5; i++) tick();
        chk("abort_reach_bit4", rise_cnt, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_tck", tck, 0); chk("abort_tms", tms, 0); chk("abort_tdi", tdi, 0);
        chk("abort_busy", busy, 0); chk("abort_rd_kept", rd_data, last_rd);
        repeat (50) tick();
        // Asynchronous reset mid-SHIFT at bit 3, then a full transaction.
        addr = 1'b0; wr_data = 8'h3C; nxt_tdo = 8'hA5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && rise_cnt < 4; i++) tick();
        chk("reset_reach_bit3", rise_cnt, 4);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_tck", tck, 0); chk("mid_rst_tms", tms, 0); chk("mid_rst_tdi", tdi, 0);
        chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0); chk("mid_rst_rd", rd_data, 0);
        model_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        addr = 1'b1; wr_data = 8'hC7; nxt_tdo = 8'h19; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (45) tick();
        // CLK_DIV=1 timing on the second instance.
        a = cyc + 1; addr = 1'b1; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("cd1_select_tms", tms2, 1);
        chk("cd1_select_tdi", tdi2, 1);
        lat = -1; rises = 0; tog = 0; p = tck2;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tck2 != p) tog++;
            if (tck2 && !p) rises++;
            p = tck2;
            if (done2 && lat < 0) begin
                lat = cyc - a;
                chk("cd1_done_busy", busy2, 0);
                chk("cd1_rd", rd2, 0);
            end
        end
        chk("cd1_latency", lat, 21);
        chk("cd1_rises", rises, 10);
        chk("cd1_toggles", tog, 20);
        // Randomized traffic with occasional aborts.
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom % 5) == 0;
            abort = ($urandom % 60) == 0;
            addr = 1'($urandom);
            wr_data = 8'($urandom);
            nxt_tdo = 8'($urandom);
            tick();
        end
        start = 1'b0; abort = 1'b0;
        repeat (50) tick();
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
